// File: rtl/fft_set_serializer.sv
// ---------------------------------------------------------------------------
// fft_set_serializer
//   Reader end of the parallel inter-stage register bank of the 64-point FFT
//   pipeline. One parallel frame of NUM_SETS complex words is captured in a
//   single cycle. It is then streamed out one word per accepted cycle on a
//   valid/ready interface. The output order is either bit-reversed or natural
//   index order. While a frame is in flight, hold_up freezes the upstream bank.
//
// Parameters
//   DATA_WIDTH  width of one complex word ([31:16] real, [15:0] imag)
//   NUM_SETS    words per parallel frame (power of two, >= 2)
//   BIT_REVERSE 1: emit indices in bit-reversed order, 0: natural order
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   parallel frame on SET_IN is valid
//   in_ready   block can capture a frame this cycle
//   hold_up    inverse of in_ready, holds the upstream register bank
//   SET_IN     flattened frame, word k at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_data   current streamed word (bit-exact copy of an input word)
//   out_index  original set index k of out_data
//   out_valid  out_data / out_index / out_last are valid
//   out_ready  downstream accepts the word this cycle
//   out_last   out_data is the final word of the frame
//   frame_cnt  number of fully emitted frames, wraps 0xFFFF -> 0
// ---------------------------------------------------------------------------
module fft_set_serializer #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_SETS    = 8,
    parameter int BIT_REVERSE = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic                           hold_up,
    input  logic [NUM_SETS*DATA_WIDTH-1:0] SET_IN,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [$clog2(NUM_SETS)-1:0]    out_index,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic [15:0]                    frame_cnt
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(NUM_SETS - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t                  state, state_next;
    logic [IDX_W-1:0]        cnt, cnt_next;       // position currently presented
    logic                    out_valid_next;
    logic [DATA_WIDTH-1:0]   out_data_next;
    logic [IDX_W-1:0]        out_index_next;
    logic                    out_last_next;
    logic [15:0]             frame_cnt_next;

    logic [DATA_WIDTH-1:0]   frame_buf [NUM_SETS];
    logic [DATA_WIDTH-1:0]   set_word  [NUM_SETS];

    logic                    transfer;
    logic                    last_xfer;
    logic                    capture;
    logic [IDX_W-1:0]        cnt_inc;
    logic [IDX_W-1:0]        inc_idx;
    logic [IDX_W-1:0]        first_idx;

    // Position -> original set index.
    function automatic logic [IDX_W-1:0] map_pos(input logic [IDX_W-1:0] p);
        logic [IDX_W-1:0] r;
        r = p;
        if (BIT_REVERSE != 0) begin
            for (int b = 0; b < IDX_W; b++) begin
                r[b] = p[IDX_W-1-b];
            end
        end
        return r;
    endfunction

    // Unpacked view of the flattened input frame.
    always_comb begin
        for (int k = 0; k < NUM_SETS; k++) begin
            set_word[k] = SET_IN[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Handshakes. The frame can be replaced on the very edge that accepts the
    // last word of the current one, which gives bubble-free back-to-back frames.
    assign transfer  = out_valid && out_ready;
    assign last_xfer = transfer && out_last;
    assign in_ready  = (state == IDLE) || last_xfer;
    assign hold_up   = ~in_ready;
    assign capture   = in_valid && in_ready;

    assign cnt_inc   = cnt + 1'b1;
    assign inc_idx   = map_pos(cnt_inc);
    assign first_idx = map_pos('0);

    // Next-state and next-output logic.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_next     = state;
        cnt_next       = cnt;
        out_valid_next = out_valid;
        out_data_next  = out_data;
        out_index_next = out_index;
        out_last_next  = out_last;
        frame_cnt_next = frame_cnt;

        if (last_xfer) begin
            frame_cnt_next = frame_cnt + 16'd1;
            state_next     = IDLE;
            out_valid_next = 1'b0;
        end else if (transfer) begin
            cnt_next       = cnt_inc;
            out_data_next  = frame_buf[inc_idx];
            out_index_next = inc_idx;
            out_last_next  = (cnt_inc == LAST_POS);
        end

        // A capture wins over the end-of-frame return to IDLE. Position 0 is
        // taken straight from SET_IN because the buffer loads on the same edge.
        if (capture) begin
            state_next     = STREAM;
            cnt_next       = '0;
            out_valid_next = 1'b1;
            out_data_next  = set_word[first_idx];
            out_index_next = first_idx;
            out_last_next  = 1'b0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments so
            // every register samples the pre-edge values of the others.
            state     <= state_next;
            cnt       <= cnt_next;
            out_valid <= out_valid_next;
            out_data  <= out_data_next;
            out_index <= out_index_next;
            out_last  <= out_last_next;
            frame_cnt <= frame_cnt_next;
        end
    end

    // Frame buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: this storage is cleared on reset on purpose. After a reset
            // it must never expose words of a discarded frame, so the reset
            // cost is accepted here.
            for (int k = 0; k < NUM_SETS; k++) begin
                frame_buf[k] <= '0;
            end
        end else if (capture) begin
            for (int k = 0; k < NUM_SETS; k++) begin
                frame_buf[k] <= set_word[k];
            end
        end
    end

endmodule

// File: tb/tb_fft_set_serializer.sv
// ---------------------------------------------------------------------------
// tb_fft_set_serializer
//   Two instances share all inputs: one emits in bit-reversed order and one
//   emits in natural order. Expected words are queued when a frame is
//   captured. They are popped and compared on every output transfer.
// ---------------------------------------------------------------------------
module tb_fft_set_serializer;

    localparam int DW = 32;
    localparam int NS = 8;
    localparam int IW = 3;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [IW-1:0] index;
        logic          last;
    } word_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [NS*DW-1:0] set_in = '0;

    logic             r_in_ready, r_hold_up, r_out_valid, r_out_last;
    logic [DW-1:0]    r_out_data;
    logic [IW-1:0]    r_out_index;
    logic [15:0]      r_frame_cnt;
    logic             n_in_ready, n_hold_up, n_out_valid, n_out_last;
    logic [DW-1:0]    n_out_data;
    logic [IW-1:0]    n_out_index;
    logic [15:0]      n_frame_cnt;

    word_t q_rev[$];
    word_t q_nat[$];
    int    xfer_cyc[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    n_xfer = 0;
    int    ready_mode = 0;
    logic  r_pend = 1'b0, n_pend = 1'b0;
    word_t r_snap, n_snap;

    fft_set_serializer #(.DATA_WIDTH(DW), .NUM_SETS(NS), .BIT_REVERSE(1)) dut_rev (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r_in_ready), .hold_up(r_hold_up),
        .SET_IN(set_in), .out_data(r_out_data), .out_index(r_out_index), .out_valid(r_out_valid),
        .out_ready(out_ready), .out_last(r_out_last), .frame_cnt(r_frame_cnt)
    );

    fft_set_serializer #(.DATA_WIDTH(DW), .NUM_SETS(NS), .BIT_REVERSE(0)) dut_nat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready), .hold_up(n_hold_up),
        .SET_IN(set_in), .out_data(n_out_data), .out_index(n_out_index), .out_valid(n_out_valid),
        .out_ready(out_ready), .out_last(n_out_last), .frame_cnt(n_frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [IW-1:0] brev(input logic [IW-1:0] p);
        logic [IW-1:0] r;
        for (int i = 0; i < IW; i++) r[i] = p[IW-1-i];
        return r;
    endfunction

    // out_ready: always high, or the repeating pattern 1,0,0.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        out_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    end

    // Monitor for the bit-reversed instance.
    always @(negedge clk) begin
        if (!rst) begin
            check("rev_valid", r_out_valid, q_rev.size() > 0);
            check("rev_hold_up", r_hold_up, !(q_rev.size() == 0 || (out_ready && q_rev[0].last)));
            if (r_pend) begin
                check("rev_stall_valid", r_out_valid, 1'b1);
                check("rev_stall_word", {r_out_data, r_out_index, r_out_last}, r_snap);
                r_pend = 1'b0;
            end
            if (r_out_valid && q_rev.size() > 0) begin
                if (out_ready) begin
                    word_t e;
                    e = q_rev.pop_front();
                    check("rev_data", r_out_data, e.data);
                    check("rev_index", r_out_index, e.index);
                    check("rev_last", r_out_last, e.last);
                    xfer_cyc.push_back(cyc);
                    n_xfer++;
                end else begin
                    r_snap = {r_out_data, r_out_index, r_out_last};
                    r_pend = 1'b1;
                end
            end
        end
    end

    // Monitor for the natural-order instance.
    always @(negedge clk) begin
        if (!rst) begin
            check("nat_valid", n_out_valid, q_nat.size() > 0);
            if (n_pend) begin
                check("nat_stall_word", {n_out_data, n_out_index, n_out_last}, n_snap);
                n_pend = 1'b0;
            end
            if (n_out_valid && q_nat.size() > 0) begin
                if (out_ready) begin
                    word_t e;
                    e = q_nat.pop_front();
                    check("nat_data", n_out_data, e.data);
                    check("nat_index", n_out_index, e.index);
                    check("nat_last", n_out_last, e.last);
                end else begin
                    n_snap = {n_out_data, n_out_index, n_out_last};
                    n_pend = 1'b1;
                end
            end
        end
    end

    // Present a frame with word k = base + k and wait for it to be captured.
    // With junk set, in_valid stays high with other data while the block is busy.
    task automatic send_frame(input logic [DW-1:0] base, input bit junk, input bit keep_valid);
        logic [NS*DW-1:0] f;
        int budget;
        word_t w;
        for (int k = 0; k < NS; k++) f[k*DW +: DW] = base + DW'(k);
        set_in   = f;
        in_valid = 1'b1;
        budget   = 0;
        @(negedge clk);
        while (!r_in_ready && budget < 300) begin
            budget++;
            @(negedge clk);
        end
        if (!r_in_ready) begin
            check("capture_timeout", 1'b0, 1'b1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < NS; p++) begin
            w.index = brev(IW'(p));
            w.data  = base + DW'(w.index);
            w.last  = (p == NS - 1);
            q_rev.push_back(w);
            w.index = IW'(p);
            w.data  = base + DW'(p);
            q_nat.push_back(w);
        end
        if (junk) begin
            set_in = ~f;
            repeat (3) begin
                @(posedge clk);
                #1;
            end
        end
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((q_rev.size() > 0 || q_nat.size() > 0) && budget < 300) begin
            budget++;
            @(negedge clk);
        end
        check("drain_timeout", q_rev.size() + q_nat.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int budget;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", r_out_valid, 1'b0);
        check("rst_in_ready", r_in_ready, 1'b1);
        check("rst_hold_up", r_hold_up, 1'b0);
        check("rst_frame_cnt", r_frame_cnt, 16'd0);
        check("rst_out_data", r_out_data, 32'd0);
        check("rst_out_index", r_out_index, 3'd0);
        check("rst_out_last", r_out_last, 1'b0);
        rst = 1'b0;

        // Bit-reversed and natural order, out_ready held high.
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        xfer_cyc.delete();
        send_frame(32'h0000_0010, 1'b0, 1'b0);
        drain();
        check("t1_xfers", xfer_cyc.size(), 8);
        if (xfer_cyc.size() == 8) check("t1_consecutive", xfer_cyc[7] - xfer_cyc[0], 7);
        check("t1_rev_frame_cnt", r_frame_cnt, 16'd1);
        check("t1_nat_frame_cnt", n_frame_cnt, 16'd1);

        // Back-pressure, with in_valid asserted while busy.
        ready_mode = 1;
        send_frame($urandom, 1'b1, 1'b0);
        drain();
        ready_mode = 0;
        check("t2_frame_cnt", r_frame_cnt, 16'd2);

        // Back-to-back frames with in_valid held high.
        repeat (2) @(posedge clk);
        #1;
        xfer_cyc.delete();
        send_frame(32'hA000_0000, 1'b0, 1'b1);
        send_frame(32'hB000_0000, 1'b0, 1'b0);
        drain();
        check("t3_xfers", xfer_cyc.size(), 16);
        if (xfer_cyc.size() == 16) check("t3_no_bubble", xfer_cyc[15] - xfer_cyc[0], 15);
        check("t3_frame_cnt", r_frame_cnt, 16'd4);

        // Reset in the middle of a frame, asserted between clock edges.
        n_xfer = 0;
        send_frame(32'hC000_0000, 1'b0, 1'b0);
        budget = 0;
        while (n_xfer < 3 && budget < 100) begin
            budget++;
            @(negedge clk);
        end
        check("t4_three_xfers", n_xfer >= 3, 1'b1);
        #2;
        rst = 1'b1;
        q_rev.delete();
        q_nat.delete();
        r_pend = 1'b0;
        n_pend = 1'b0;
        #1;
        check("t4_rst_out_valid", r_out_valid, 1'b0);
        check("t4_rst_in_ready", r_in_ready, 1'b1);
        check("t4_rst_hold_up", r_hold_up, 1'b0);
        check("t4_rst_frame_cnt", r_frame_cnt, 16'd0);
        check("t4_rst_nat_valid", n_out_valid, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t4_no_glitch", r_out_valid, 1'b0);
        send_frame(32'hD000_0000, 1'b0, 1'b0);
        drain();
        check("t4_frame_cnt", r_frame_cnt, 16'd1);

        // frame_cnt wrap on the natural-order instance.
        force dut_nat.frame_cnt = 16'hFFFF;
        #1;
        release dut_nat.frame_cnt;
        check("t5_preload", n_frame_cnt, 16'hFFFF);
        send_frame(32'hE000_0000, 1'b0, 1'b0);
        drain();
        check("t5_wrap", n_frame_cnt, 16'h0000);
        check("t5_rev_frame_cnt", r_frame_cnt, 16'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
